// File: rtl/fft_pkg.sv
// Shared constants and the compare-FSM state type for the FFT peak detector.
package fft_pkg;

    localparam int N_POINT_DEF = 1024;
    localparam int IDX_W_DEF   = 10;
    localparam int POW_W       = 32;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ACC  = 1'b1
    } state_e;

endpackage

// File: rtl/cplx_mag2.sv
// Two-stage |x|^2 pipeline: squares registered in stage 1, unsigned sum in stage 2.
module cplx_mag2
    import fft_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             di_en,
    input  logic             di_last,
    input  logic [31:0]      din,
    output logic             pow_en,
    output logic             pow_last,
    output logic [POW_W-1:0] pow_data
);

    logic signed [15:0] re;
    logic signed [15:0] im;
    logic signed [31:0] re_sq;
    logic signed [31:0] im_sq;

    logic        v1_q, v1_d;
    logic        l1_q, l1_d;
    logic [31:0] re2_q, re2_d;
    logic [31:0] im2_q, im2_d;
    logic        v2_q, v2_d;
    logic        l2_q, l2_d;
    logic [POW_W-1:0] pow_q, pow_d;

    assign re = din[15:0];
    assign im = din[31:16];

    // Each square is at most 2^30, so the 32-bit sum can never wrap.
    always_comb begin
        re_sq = re * re;
        im_sq = im * im;
        v1_d  = di_en;
        l1_d  = di_en & di_last;
        re2_d = di_en ? re_sq : re2_q;
        im2_d = di_en ? im_sq : im2_q;
        v2_d  = v1_q;
        l2_d  = l1_q;
        pow_d = v1_q ? (re2_q + im2_q) : pow_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q  <= 1'b0;
            l1_q  <= 1'b0;
            re2_q <= '0;
            im2_q <= '0;
            v2_q  <= 1'b0;
            l2_q  <= 1'b0;
            pow_q <= '0;
        end else begin
            v1_q  <= v1_d;
            l1_q  <= l1_d;
            re2_q <= re2_d;
            im2_q <= im2_d;
            v2_q  <= v2_d;
            l2_q  <= l2_d;
            pow_q <= pow_d;
        end
    end

    assign pow_en   = v2_q;
    assign pow_last = l2_q;
    assign pow_data = pow_q;

endmodule

// File: rtl/fft_peak_detect.sv
// Per-frame peak search over the FFT power stream. Define FFT_PEAK_DC_SKIP_EN
// to exclude bin 0 (DC) from the search.
module fft_peak_detect
    import fft_pkg::*;
#(
    parameter int N_POINT = N_POINT_DEF,
    parameter int IDX_W   = IDX_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             di_en,
    input  logic             di_last,
    input  logic [31:0]      din,
    output logic             pow_en,
    output logic             pow_last,
    output logic [POW_W-1:0] pow_data,
    output logic             peak_en,
    output logic [IDX_W-1:0] peak_idx,
    output logic [POW_W-1:0] peak_pow,
    output logic             frm_err,
    output logic             dbg_state
);

    localparam logic [IDX_W-1:0] LAST_CNT = IDX_W'(N_POINT - 1);

    state_e           state_q, state_d;
    logic [IDX_W-1:0] cnt_q, cnt_d;
    logic [POW_W-1:0] max_q, max_d;
    logic [IDX_W-1:0] midx_q, midx_d;
    logic             peak_en_q, peak_en_d;
    logic [IDX_W-1:0] peak_idx_q, peak_idx_d;
    logic [POW_W-1:0] peak_pow_q, peak_pow_d;
    logic             frm_err_q, frm_err_d;

    logic             first;
    logic             at_end;
    logic [IDX_W-1:0] cand_idx;
    logic [POW_W-1:0] cand_pow;

    cplx_mag2 u_mag2 (
        .clk      (clk),
        .rst_n    (rst_n),
        .di_en    (di_en),
        .di_last  (di_last),
        .din      (din),
        .pow_en   (pow_en),
        .pow_last (pow_last),
        .pow_data (pow_data)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        max_d      = max_q;
        midx_d     = midx_q;
        peak_en_d  = 1'b0;
        peak_idx_d = peak_idx_q;
        peak_pow_d = peak_pow_q;
        frm_err_d  = 1'b0;
        first      = (state_q == ST_IDLE);
        at_end     = (cnt_q == LAST_CNT);
        cand_idx   = midx_q;
        cand_pow   = max_q;

        if (pow_en) begin
`ifdef FFT_PEAK_DC_SKIP_EN
            // DC is seeded as power 0 so a frame with no energy elsewhere reports idx 0.
            if (first) begin
                cand_idx = '0;
                cand_pow = '0;
            end else if (pow_data > max_q) begin
                cand_idx = cnt_q;
                cand_pow = pow_data;
            end
`else
            if (first || (pow_data > max_q)) begin
                cand_idx = cnt_q;
                cand_pow = pow_data;
            end
`endif
            max_d  = cand_pow;
            midx_d = cand_idx;

            if (pow_last || at_end) begin
                peak_en_d  = 1'b1;
                peak_idx_d = cand_idx;
                peak_pow_d = cand_pow;
                frm_err_d  = pow_last ^ at_end;
                state_d    = ST_IDLE;
                cnt_d      = '0;
            end else begin
                state_d = ST_ACC;
                cnt_d   = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            max_q      <= '0;
            midx_q     <= '0;
            peak_en_q  <= 1'b0;
            peak_idx_q <= '0;
            peak_pow_q <= '0;
            frm_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            max_q      <= max_d;
            midx_q     <= midx_d;
            peak_en_q  <= peak_en_d;
            peak_idx_q <= peak_idx_d;
            peak_pow_q <= peak_pow_d;
            frm_err_q  <= frm_err_d;
        end
    end

    assign peak_en   = peak_en_q;
    assign peak_idx  = peak_idx_q;
    assign peak_pow  = peak_pow_q;
    assign frm_err   = frm_err_q;
    assign dbg_state = state_q;

endmodule
